// File: rtl/fifo16x4_ctrl.sv
// fifo16x4_ctrl: FWFT FIFO controller for an external 16x4 async-read RAM plus a registered output word
module fifo16x4_ctrl #(
    parameter int AFULL_LVL  = 14,
    parameter int AEMPTY_LVL = 2
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [3:0] di_i,
    input  logic       push_i,
    input  logic       pop_i,
    output logic [3:0] do_o,
    output logic       dvalid_o,
    output logic       full_o,
    output logic       empty_o,
    output logic       afull_o,
    output logic       aempty_o,
    output logic [4:0] count_o,
    output logic       ovf_o,
    output logic       unf_o,
    output logic [3:0] ram_wad_o,
    output logic [3:0] ram_di_o,
    output logic       ram_wre_o,
    output logic [3:0] ram_rad_o,
    input  logic [3:0] ram_do_i
);
    localparam logic [4:0] AF = 5'(AFULL_LVL);
    localparam logic [4:0] AE = 5'(AEMPTY_LVL);
    logic [3:0] wptr_q, wptr_d, rptr_q, rptr_d, do_q, do_d;
    logic [4:0] ram_cnt_q, ram_cnt_d;
    logic       dvalid_q, dvalid_d, ovf_q, ovf_d, unf_q, unf_d;
    logic       push_ok, pop_ok, load;
    assign push_ok = push_i & ~full_o;
    assign pop_ok  = pop_i & dvalid_q;
    // refill the output word whenever it is empty or being consumed; uses pre-edge ram_cnt so no bypass
    assign load    = (ram_cnt_q != 5'd0) & (~dvalid_q | pop_i);
    // next-state decode for pointers, occupancy, output word and sticky error flags
    always_comb begin
        wptr_d    = push_ok ? wptr_q + 4'd1 : wptr_q;
        rptr_d    = load ? rptr_q + 4'd1 : rptr_q;
        ram_cnt_d = ram_cnt_q + {4'd0, push_ok} - {4'd0, load};
        do_d      = load ? ram_do_i : do_q;
        dvalid_d  = load | (dvalid_q & ~pop_ok);
        ovf_d     = ovf_q | (push_i & full_o);
        unf_d     = unf_q | (pop_i & ~dvalid_q);
    end
    // state registers with synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr_q    <= 4'd0;
            rptr_q    <= 4'd0;
            ram_cnt_q <= 5'd0;
            do_q      <= 4'h0;
            dvalid_q  <= 1'b0;
            ovf_q     <= 1'b0;
            unf_q     <= 1'b0;
        end else begin
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            ram_cnt_q <= ram_cnt_d;
            do_q      <= do_d;
            dvalid_q  <= dvalid_d;
            ovf_q     <= ovf_d;
            unf_q     <= unf_d;
        end
    end
    assign count_o   = ram_cnt_q + {4'd0, dvalid_q};
    assign full_o    = ram_cnt_q == 5'd16;
    assign empty_o   = count_o == 5'd0;
    assign afull_o   = count_o >= AF;
    assign aempty_o  = count_o <= AE;
    assign do_o      = do_q;
    assign dvalid_o  = dvalid_q;
    assign ovf_o     = ovf_q;
    assign unf_o     = unf_q;
    assign ram_wad_o = wptr_q;
    assign ram_di_o  = di_i;
    assign ram_wre_o = push_ok & ~rst_i;
    assign ram_rad_o = rptr_q;
endmodule

// File: doc/fifo16x4_ctrl.md
# fifo16x4_ctrl

Synchronous first-word-fall-through FIFO controller that drives one external 16x4 distributed dual-port RAM (registered write port, asynchronous read port) and adds a registered output stage. It sits directly upstream of that RAM on the write side and downstream of it on the read side: it generates write address, data and enable, steers the read address, and captures RAM read data into its output register. Total storage is 17 words: 16 in RAM plus 1 in the output register.

## Interface
Parameters:
- AFULL_LVL, 14, AFULL asserts when COUNT >= AFULL_LVL (legal 1..17)
- AEMPTY_LVL, 2, AEMPTY asserts when COUNT <= AEMPTY_LVL (legal 0..16)

Ports:
- CLK  in  1  single clock; all state changes on rising edge
- RST  in  1  reset; synchronous, active-high
- DI  in  4  push data
- PUSH  in  1  push request; accepted when FULL=0
- POP  in  1  pop request; accepted when DVALID=1
- DO  out  4  head-of-FIFO data, registered
- DVALID  out  1  DO holds a valid word
- FULL  out  1  RAM holds 16 words; pushes refused
- EMPTY  out  1  COUNT==0
- AFULL / AEMPTY  out  1 each  threshold flags
- COUNT  out  5  total words held, 0..17
- OVF / UNF  out  1 each  sticky: refused push / refused pop seen
- RAM_WAD  out  4  RAM write address (= wptr)
- RAM_DI  out  4  RAM write data (= DI)
- RAM_WRE  out  1  RAM write enable
- RAM_RAD  out  4  RAM read address (= rptr)
- RAM_DO  in  4  RAM asynchronous read data

## Operation
- State: wptr[3:0], rptr[3:0] (both wrap 15->0 modulo 16), ram_cnt[4:0] (0..16), DO register, DVALID, OVF, UNF.
- push_ok = PUSH & ~FULL. RAM_WRE = push_ok & ~RST, combinational; RAM_WAD/RAM_DI are driven combinationally from wptr and DI. The RAM captures the write on the same edge; wptr increments on that edge.
- load = (ram_cnt != 0) & (~DVALID | POP). On load: DO <= RAM_DO (addressed by RAM_RAD = rptr), rptr increments, DVALID <= 1.
- pop_ok = POP & DVALID. pop_ok without load: DVALID <= 0; DO keeps its stale value.
- ram_cnt next = ram_cnt + push_ok - load. COUNT = ram_cnt + DVALID.
- FULL = (ram_cnt == 16). EMPTY = (COUNT == 0). Flags decode registered state combinationally and change only on clock edges.
- A push with FULL=1 is dropped, and OVF sets. A pop with DVALID=0 is ignored, and UNF sets. OVF and UNF clear only on RST.
- Simultaneous push_ok and load are both performed. The load uses ram_cnt from before the edge, so a push into an empty RAM never bypasses to DO in the same edge.
- PUSH while FULL and POP are both active: the push is still refused (FULL is evaluated from pre-edge state). The pop and load proceed.
- Wrap-around: when wptr == rptr, ram_cnt alone distinguishes 0 from 16.
- RST: wptr, rptr, ram_cnt = 0; DO = 4'h0; DVALID = 0; OVF = UNF = 0. Hence COUNT = 0, EMPTY = 1, FULL = 0, AEMPTY = 1, AFULL = 0. RST overrides PUSH and POP in the same cycle, and RAM_WRE = 0 while RST is high. RAM contents are not cleared.

## Timing
- Push-to-DVALID latency into an empty FIFO: 2 edges. Edge 1 writes the RAM; edge 2 loads DO.
- Pop-to-next-word: if ram_cnt > 0, the next word is on DO after the same edge that accepts the pop. Back-to-back pops therefore sustain one word per cycle.
- With continuous PUSH and POP in steady state, throughput is 1 word/cycle and COUNT stays constant.
- COUNT, FULL, EMPTY, AFULL and AEMPTY update on the edge following the event that changes them. OVF and UNF set on the edge of the refused request.
- No combinational path exists from PUSH/POP to DO, DVALID, or the flags. Only RAM_WRE, RAM_WAD and RAM_DI are combinational, from PUSH, DI and state.

## Test plan
- Basic fall-through: after reset, push 4'h1, 4'h2, 4'h3 on consecutive cycles with no pop. Required: DVALID=1 with DO=4'h1 two edges after the first push; final COUNT=3; EMPTY=0.
- Fill and overflow: push 4'h0..4'hF, then 4'h5 (17 pushes, no pops). Required: COUNT=17, FULL=1, AFULL=1. An 18th push of 4'hA is refused: OVF=1, COUNT stays 17. Draining then yields exactly 0..F, 5 in order, then EMPTY=1.
- Wrap-around streaming: push 40 incrementing values (mod 16) while popping whenever DVALID=1. Required: output sequence is identical to the input sequence, with pointers wrapping at least twice.
- Simultaneous push+pop at FULL: with COUNT=17, assert PUSH (4'h7) and POP together. Required: COUNT=16, FULL=0, 4'h7 not stored, OVF=1.
- Underflow: from reset, assert POP for 3 cycles. Required: UNF=1, COUNT=0, DVALID=0.
- Reset mid-operation: with COUNT=9 and OVF=1, assert RST for one cycle while PUSH and POP are high. Required after the edge: COUNT=0, DVALID=0, DO=4'h0, OVF=0, RAM_WRE=0 during RST. A following push of 4'hC appears on DO two edges later.
